regfile_writeback: RTL

//  Write-side front end of the 10-bit CPU register file. Accepts results from
//  the ALU and the memory-load path over valid/ready handshakes and queues them
//  in a small in-order FIFO. Drains the queue one write per cycle onto the

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/regfile_writeback_if.sv | 41 ++++
 rtl/regfile_writeback_fifo.sv | 82 ++++++++
 rtl/regfile_writeback.sv | 79 +++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data/select widths, register names and the
// write-back queue entry layout used by the register file front end.
package cpu_pkg;

    localparam int DW       = 10;
    localparam int AW       = 3;
    localparam int WB_DEPTH = 4;

    localparam logic [AW-1:0] REG_LA   = 3'd0;
    localparam logic [AW-1:0] REG_S0   = 3'd1;
    localparam logic [AW-1:0] REG_S1   = 3'd2;
    localparam logic [AW-1:0] REG_T0   = 3'd3;
    localparam logic [AW-1:0] REG_T1   = 3'd4;
    localparam logic [AW-1:0] REG_T2   = 3'd5;
    localparam logic [AW-1:0] REG_T3   = 3'd6;
    localparam logic [AW-1:0] REG_ZERO = 3'd7;

    typedef struct packed {
        logic [AW-1:0] dest;
        logic [DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_if.sv
// Bundle of the result handshakes, the register file write port and the
// status outputs of the write-back front end.
interface regfile_writeback_if #(
    parameter int DEPTH = cpu_pkg::WB_DEPTH
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                   alu_valid;
    logic [cpu_pkg::AW-1:0] alu_dest;
    logic [cpu_pkg::DW-1:0] alu_data;
    logic                   alu_ready;
    logic                   mem_valid;
    logic [cpu_pkg::AW-1:0] mem_dest;
    logic [cpu_pkg::DW-1:0] mem_data;
    logic                   mem_ready;
    logic                   wb_hold;
    logic [cpu_pkg::DW-1:0] rf_wdata;
    logic [cpu_pkg::AW-1:0] rf_wsel;
    logic                   rf_wen;
    logic [6:0]             pending;
    logic [CW-1:0]          q_count;

    modport master (
        output alu_valid, alu_dest, alu_data,
        output mem_valid, mem_dest, mem_data,
        output wb_hold,
        input  alu_ready, mem_ready,
        input  rf_wdata, rf_wsel, rf_wen,
        input  pending, q_count
    );

    modport slave (
        input  alu_valid, alu_dest, alu_data,
        input  mem_valid, mem_dest, mem_data,
        input  wb_hold,
        output alu_ready, mem_ready,
        output rf_wdata, rf_wsel, rf_wen,
        output pending, q_count
    );

endinterface

// File: rtl/regfile_writeback_fifo.sv
// In-order write-back queue. Besides the head entry and occupancy count it
// exposes every slot's destination and occupied flag so the parent can build
// the pending-register mask without extra state.
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int  DEPTH = WB_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  wb_entry_t                pushEntry_i,
    input  logic                     pop_i,
    output wb_entry_t                head_o,
    output logic [CW-1:0]            count_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [DEPTH-1:0]         occupied_o,
    output logic [DEPTH-1:0][AW-1:0] dest_o
);

    wb_entry_t        entries_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             doPush, doPop;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign doPush     = push_i & ~full_o;
    assign doPop      = pop_i & ~empty_o;
    assign count_o    = count_q;
    assign occupied_o = valid_q;
    assign head_o     = entries_q[rdPtr_q];

    // Next pointers wrap naturally because DEPTH is a power of two; a
    // simultaneous push and pop leaves the count unchanged.
    always_comb begin
        wrPtr_d = doPush ? wrPtr_q + PW'(1) : wrPtr_q;
        rdPtr_d = doPop  ? rdPtr_q + PW'(1) : rdPtr_q;
        case ({doPush, doPop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Expose each slot's destination for the pending-mask reduction.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            dest_o[e] = entries_q[e].dest;
        end
    end

    // Slot storage, occupied flags, pointers and count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int e = 0; e < DEPTH; e++) begin
                entries_q[e] <= '0;
            end
            valid_q <= '0;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                entries_q[wrPtr_q] <= pushEntry_i;
                valid_q[wrPtr_q]   <= 1'b1;
            end
            if (doPop) begin
                valid_q[rdPtr_q] <= 1'b0;
            end
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Write-side front end of the register file: arbitrates ALU and load results
// into an in-order queue, drains one write per cycle to the register file and
// reports which registers still have writes in flight.
module regfile_writeback
    import cpu_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                clk,
    input  logic                reset_n,
    regfile_writeback_if.slave  bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    wb_entry_t                pushEntry;
    wb_entry_t                headEntry;
    logic [CW-1:0]            count;
    logic                     full, empty;
    logic                     memFire, aluFire, push, pop;
    logic [DEPTH-1:0]         occupied;
    logic [DEPTH-1:0][AW-1:0] entryDest;
    logic [6:0]               pendingMask;

    // Readiness looks only at the registered occupancy, so a full queue that
    // is draining this cycle still refuses input; loads win over ALU results.
    assign bus.mem_ready = ~full;
    assign bus.alu_ready = ~full & ~bus.mem_valid;

    assign pop          = ~empty & ~bus.wb_hold;
    assign bus.rf_wen   = pop;
    assign bus.rf_wdata = headEntry.data;
    assign bus.rf_wsel  = headEntry.dest;
    assign bus.pending  = pendingMask;
    assign bus.q_count  = count;

    // Pick the accepted source and drop writes aimed at the zero register.
    always_comb begin
        memFire = bus.mem_valid & ~full;
        aluFire = bus.alu_valid & ~full & ~bus.mem_valid;
        if (memFire) begin
            pushEntry.dest = bus.mem_dest;
            pushEntry.data = bus.mem_data;
        end else begin
            pushEntry.dest = bus.alu_dest;
            pushEntry.data = bus.alu_data;
        end
        push = (memFire | aluFire) & (pushEntry.dest != REG_ZERO);
    end

    // A register is pending while any occupied slot targets it.
    always_comb begin
        pendingMask = '0;
        for (int r = 0; r < 7; r++) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (occupied[e] && (entryDest[e] == AW'(r))) begin
                    pendingMask[r] = 1'b1;
                end
            end
        end
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (push),
        .pushEntry_i (pushEntry),
        .pop_i       (pop),
        .head_o      (headEntry),
        .count_o     (count),
        .full_o      (full),
        .empty_o     (empty),
        .occupied_o  (occupied),
        .dest_o      (entryDest)
    );

endmodule
